mesh_loader: RTL

//  Upstream stage of the subdivision pipeline: accepts a base mesh as a 32-bit valid/ready word stream and writes it into
//  the OBJ RAM (RAM0) in the layout subdiv consumes. After a clean load it pulses start to the subsurf top and waits for
//  its busy to fall. Header errors, short streams and long streams are flagged, and the pipeline is not kicked.

---
 rtl/subsurf_pkg.sv | 36 +++
 rtl/mesh_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/subsurf_pkg.sv
// rtl/subsurf_pkg.sv - shared constants, loader state and error codes for the subdivision pipeline
package subsurf_pkg;

  localparam int ADDR_WIDTH   = 9;
  localparam int DEPTH        = 2 ** ADDR_WIDTH;
  localparam int VERTEX_WORDS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_F,
    S_BODY,
    S_DRAIN,
    S_KICK,
    S_WAIT_HI,
    S_WAIT_LO,
    S_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_HDR   = 2'd1,
    ERR_SHORT = 2'd2,
    ERR_LONG  = 2'd3
  } err_code_t;

  // Wide enough that 32-bit V and F counts can never wrap the word total.
  function automatic logic [35:0] mesh_total(input logic [31:0] v, input logic [31:0] f,
                                             input int unsigned face_words);
    logic [35:0] v_ext;
    logic [35:0] f_ext;
    v_ext = {4'b0, v};
    f_ext = {4'b0, f};
    return 36'd2 + v_ext * 36'(VERTEX_WORDS) + f_ext * 36'(face_words);
  endfunction

endpackage

// File: rtl/mesh_loader.sv
// rtl/mesh_loader.sv - streams a base mesh into RAM0 and kicks the subsurf top after a clean load
module mesh_loader #(
  parameter int ADDR_WIDTH = subsurf_pkg::ADDR_WIDTH,
  parameter int FACE_WORDS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  en,
  output logic [ADDR_WIDTH-1:0] a,
  output logic [3:0]            we,
  output logic [31:0]           di,
  output logic                  ss_start,
  input  logic                  ss_busy,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);
  import subsurf_pkg::*;

  localparam logic [35:0] RAM_DEPTH = 36'(1) << ADDR_WIDTH;

  loader_state_t         state;
  err_code_t             err_q;
  logic [31:0]           v_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [35:0]           total;
  logic                  hdr_bad;

  assign total   = mesh_total(v_q, s_data, FACE_WORDS);
  assign hdr_bad = (v_q == 32'd0) || (s_data == 32'd0) || (total > RAM_DEPTH);
  assign s_ready = (state == S_IDLE) || (state == S_HDR_F) || (state == S_BODY) || (state == S_DRAIN);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      err_q    <= ERR_NONE;
      v_q      <= '0;
      idx      <= '0;
      last_idx <= '0;
      en       <= 1'b0;
      we       <= 4'h0;
      a        <= '0;
      di       <= '0;
      ss_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // RAM port and pulses idle unless a branch below drives them this cycle.
      en       <= 1'b0;
      we       <= 4'h0;
      a        <= '0;
      di       <= '0;
      ss_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: if (s_valid) begin
          en    <= 1'b1;
          we    <= 4'hF;
          di    <= s_data;
          v_q   <= s_data;
          err_q <= ERR_NONE;
          busy  <= 1'b1;
          if (s_last) begin
            err_q <= ERR_SHORT;
            state <= S_ERR;
          end else begin
            state <= S_HDR_F;
          end
        end
        S_HDR_F: if (s_valid) begin
          en       <= 1'b1;
          we       <= 4'hF;
          a        <= ADDR_WIDTH'(1);
          di       <= s_data;
          idx      <= ADDR_WIDTH'(2);
          last_idx <= ADDR_WIDTH'(total - 36'd1);
          if (hdr_bad) begin
            err_q <= ERR_HDR;
            state <= s_last ? S_ERR : S_DRAIN;
          end else if (s_last) begin
            err_q <= ERR_SHORT;
            state <= S_ERR;
          end else begin
            state <= S_BODY;
          end
        end
        S_BODY: if (s_valid) begin
          en <= 1'b1;
          we <= 4'hF;
          a  <= idx;
          di <= s_data;
          if (idx == last_idx) begin
            if (s_last) begin
              state <= S_KICK;
            end else begin
              err_q <= ERR_LONG;
              state <= S_DRAIN;
            end
          end else if (s_last) begin
            err_q <= ERR_SHORT;
            state <= S_ERR;
          end else begin
            idx <= idx + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: if (s_valid && s_last) state <= S_ERR;
        // KICK follows the cycle that carried the final RAM write, so start lands after it.
        S_KICK: begin
          ss_start <= 1'b1;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: if (ss_busy) state <= S_WAIT_LO;
        S_WAIT_LO: if (!ss_busy) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
